unsigned_32_bit_accumulator: RTL and testbench

//  Sequential stage directly downstream of unsigned_32_bit_adder.

---
 rtl/acc_pkg.sv | 13 +
 rtl/unsigned_32_bit_adder.sv | 14 +
 rtl/unsigned_32_bit_accumulator.sv | 99 +++++++++
 tb/tb_unsigned_32_bit_accumulator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and default sizing for the multi-operand accumulator.
package acc_pkg;

  localparam int ACC_WIDTH   = 32;
  localparam int ACC_COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

endpackage

// File: rtl/unsigned_32_bit_adder.sv
// Combinational unsigned adder with carry-in and carry-out.
module unsigned_32_bit_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic [WIDTH-1:0] sout,
  output logic             cout
);

  assign {cout, sout} = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/unsigned_32_bit_accumulator.sv
// Sums a programmed number of operands from a valid/ready stream and returns
// the wrapped total plus a sticky carry-out flag on a valid/ready result port.
//
//  state | meaning
//  IDLE  | waiting for start; no handshakes active
//  ACC   | accepting operand beats until the programmed count is reached
//  DONE  | result presented, held until the consumer takes it
module unsigned_32_bit_accumulator
  import acc_pkg::*;
#(
  parameter int WIDTH   = ACC_WIDTH,
  parameter int COUNT_W = ACC_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_ops,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               overflow,
  output logic               busy
);

  acc_state_t         state;
  logic [WIDTH-1:0]   acc;
  logic [COUNT_W-1:0] remaining;
  logic               ovf;
  logic               in_ready_q;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic               beat;

  unsigned_32_bit_adder #(.WIDTH(WIDTH)) u_adder (
    .in1  (acc),
    .in2  (in_data),
    .cin  (1'b0),
    .sout (add_sum),
    .cout (add_cout)
  );

  assign beat = in_valid && in_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      remaining  <= '0;
      ovf        <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= num_ops;
            if (num_ops != '0) begin
              state      <= ACC;
              in_ready_q <= 1'b1;
            end else begin
              state <= DONE;
            end
          end
        end
        ACC: begin
          if (beat) begin
            acc       <= add_sum;
            ovf       <= ovf | add_cout;
            remaining <= remaining - COUNT_W'(1);
            // Last beat: drop ready together with the state change so no
            // extra operand can slip in behind the final one.
            if (remaining == COUNT_W'(1)) begin
              state      <= DONE;
              in_ready_q <= 1'b0;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = acc;
  assign overflow  = ovf;

endmodule

// File: tb/tb_unsigned_32_bit_accumulator.sv
// Randomized self-checking bench; expected totals come from 64-bit sums of the
// operand list, with overflow meaning the unwrapped total reached 2**32.
module tb_unsigned_32_bit_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  num_ops;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        overflow;
  logic        busy;

  logic [31:0] beats [256];
  int n_checks;
  int n_pass;

  unsigned_32_bit_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_ops   (num_ops),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Runs one job over beats[0..n-1]; entered and left at a falling edge.
  task automatic run_job(input int n, input int valid_pct, input int hold, input bit noise);
    logic [63:0] total;
    logic [63:0] partial;
    int idx;
    int cyc;
    total = 0;
    for (int i = 0; i < n; i++) total += 64'(beats[i]);
    partial = 0;
    idx = 0;
    cyc = 0;

    start   = 1'b1;
    num_ops = n[7:0];
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", busy, 1);

    while (idx < n && cyc < 4000) begin
      check_val("in_ready_acc", in_ready, 1);
      check_val("sum_partial", sum, partial[31:0]);
      in_valid = ($urandom_range(99) < valid_pct);
      in_data  = in_valid ? beats[idx] : $urandom;
      start    = noise ? 1'($urandom_range(1)) : 1'b0;
      num_ops  = 8'($urandom);
      @(posedge clk);
      if (in_valid) begin
        partial += 64'(beats[idx]);
        idx++;
      end
      cyc++;
      @(negedge clk);
    end
    check_val("beat_timeout", 64'(idx), 64'(n));

    in_valid = 1'b0;
    start    = 1'b0;
    check_val("out_valid_done", out_valid, 1);
    check_val("in_ready_done", in_ready, 0);
    check_val("sum_done", sum, total[31:0]);
    check_val("ovf_done", overflow, |total[63:32]);

    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(1));
      in_data   = $urandom;
      start     = noise ? 1'($urandom_range(1)) : 1'b0;
      num_ops   = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_val("out_valid_hold", out_valid, 1);
      check_val("sum_hold", sum, total[31:0]);
      check_val("ovf_hold", overflow, |total[63:32]);
    end

    out_ready = 1'b1;
    in_valid  = 1'b0;
    start     = noise;
    num_ops   = 8'd3;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check_val("out_valid_after_hs", out_valid, 0);
    check_val("busy_after_hs", busy, 0);
    @(negedge clk);
    check_val("no_restart_from_done", busy, 0);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    num_ops   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_sum", sum, 0);
    check_val("rst_ovf", overflow, 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: reset in the middle of a job discards it
    start = 1'b1; num_ops = 8'd5;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    @(negedge clk);
    in_data = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_in_ready", in_ready, 0);
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_sum", sum, 0);
    check_val("midrst_ovf", overflow, 0);
    @(negedge clk);

    // T2
    beats[0] = 32'd1000; beats[1] = 32'd1010; beats[2] = 32'd25;
    run_job(3, 100, 0, 1'b0);

    // T3
    beats[0] = 32'hFFFF_FFFF; beats[1] = 32'hFFFF_FFFF;
    run_job(2, 100, 1, 1'b0);

    // T4
    for (int i = 0; i < 4; i++) beats[i] = $urandom;
    run_job(4, 50, 5, 1'b0);

    // T5
    run_job(0, 100, 2, 1'b0);

    for (int j = 0; j < 8; j++) begin
      int n;
      n = $urandom_range(20, 1);
      for (int i = 0; i < n; i++)
        beats[i] = (j % 2 == 0) ? $urandom : 32'($urandom_range(65535));
      run_job(n, 60, $urandom_range(3), 1'b1);
    end

    // T6: start noise during ACC/DONE, then a full-length job
    for (int i = 0; i < 255; i++) beats[i] = 32'd1;
    run_job(255, 100, 1, 1'b1);
    for (int i = 0; i < 255; i++) beats[i] = 32'hFFFF_FFFF;
    run_job(255, 70, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
